// File: rtl/fifo_burst_reader.sv
// Drains BURST_LEN-word bursts from an FWFT FIFO into a registered valid/ready stream; first word 2 cycles after start.
// Zero-cycle stall on m_ready=0 (no skid); define FIFO_BURST_READER_ERRCNT_EN for a saturating read-error counter.
module fifo_burst_reader #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_almost_empty,
  input  logic [DATA_W-1:0] i_fifo_rdata,
  input  logic              i_fifo_rderr,
  output logic              o_fifo_rden,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  output logic              o_m_last,
  input  logic              i_m_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_burst_cnt,
  output logic              o_err_sticky,
  output logic [15:0]       o_err_cnt
);

  localparam int WCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(BURST_LEN - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_err_sticky;

  logic                w_rden;
  logic                w_hs;
  logic                w_last_idx;

  // Pop only when the output register is free or being drained this cycle.
  assign w_rden     = (r_state == S_BURST) && !i_fifo_empty && (!r_m_valid || i_m_ready);
  assign w_hs       = r_m_valid && i_m_ready;
  assign w_last_idx = (r_wcnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_burst_cnt  <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && !i_fifo_almost_empty) begin
            r_state <= S_BURST;
            r_wcnt  <= '0;
          end
        end
        S_BURST: begin
          if (w_rden && w_last_idx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_rden) begin
        r_m_data  <= i_fifo_rdata;
        r_m_valid <= 1'b1;
        r_m_last  <= w_last_idx;
        r_wcnt    <= r_wcnt + WCNT_W'(1);
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end

      if (w_hs && r_m_last) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      if (i_fifo_rderr)     r_err_sticky <= 1'b1;
    end
  end

`ifdef FIFO_BURST_READER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (i_fifo_rderr && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  assign o_fifo_rden  = w_rden;
  assign o_m_data     = r_m_data;
  assign o_m_valid    = r_m_valid;
  assign o_m_last     = r_m_last;
  assign o_busy       = (r_state == S_BURST);
  assign o_burst_cnt  = r_burst_cnt;
  assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-level model of FIFO, burst budget and output register, checked every cycle.
module tb_fifo_burst_reader;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, fifo_empty, fifo_ae, fifo_rderr, m_ready;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden, m_valid, m_last, busy, err_sticky;
  logic [DW-1:0] m_data;
  logic [CW-1:0] burst_cnt;
  logic [15:0]   err_cnt;

  fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .i_fifo_almost_empty(fifo_ae), .i_fifo_rdata(fifo_rdata), .i_fifo_rderr(fifo_rderr),
    .o_fifo_rden(fifo_rden), .o_m_data(m_data), .o_m_valid(m_valid), .o_m_last(m_last),
    .i_m_ready(m_ready), .o_busy(busy), .o_burst_cnt(burst_cnt),
    .o_err_sticky(err_sticky), .o_err_cnt(err_cnt)
  );

  typedef struct { logic [DW-1:0] d; bit l; } beat_t;

  logic [DW-1:0] fq[$];
  bit            force_empty;
  logic [DW-1:0] nextw;

  // Model: words still owed in the current burst, and what sits in the output register.
  beat_t         outq[$];
  int            words_left;
  int unsigned   bc_m;
  int            ec_m;
  bit            es_m;

  logic [DW-1:0] hs_d[$];
  bit            hs_l[$];
  int            hs_c[$];

  int n_checks, n_err, cyc;
  int cnt_rden, cnt_valid, valid_low, stall_rden;
  bit prev_stall;
  logic [DW-1:0] prev_d;
  bit prev_l;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void refresh();
    fifo_empty = force_empty || (fq.size() == 0);
    fifo_ae    = (fq.size() < BL);
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  endfunction

  function automatic void load_fresh(int n);
    fq.delete();
    nextw = 1;
    for (int i = 0; i < n; i++) begin
      fq.push_back(nextw);
      nextw++;
    end
    refresh();
  endfunction

  function automatic void clear_logs();
    hs_d.delete(); hs_l.delete(); hs_c.delete();
    cnt_rden = 0; cnt_valid = 0; valid_low = 0; stall_rden = 0;
  endfunction

  task automatic tick();
    bit exp_rden, hs, pop;
    @(negedge clk);
    exp_rden = (words_left > 0) && !fifo_empty && (outq.size() == 0 || m_ready);
    if (!rst) chk("rden", 64'(fifo_rden), 64'(exp_rden));
    chk("busy", 64'(busy), 64'(words_left > 0));
    chk("m_valid", 64'(m_valid), 64'(outq.size() > 0));
    if (outq.size() > 0) begin
      chk("m_data", m_data, outq[0].d);
      chk("m_last", 64'(m_last), 64'(outq[0].l));
    end
    chk("burst_cnt", 64'(burst_cnt), 64'(bc_m));
    chk("err_sticky", 64'(err_sticky), 64'(es_m));
`ifdef FIFO_BURST_READER_ERRCNT_EN
    chk("err_cnt", 64'(err_cnt), 64'(ec_m));
`else
    chk("err_cnt", 64'(err_cnt), 64'd0);
`endif
    if (prev_stall) begin
      chk("stall_data", m_data, prev_d);
      chk("stall_last", 64'(m_last), 64'(prev_l));
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_d = m_data;
    prev_l = m_last;
    if (!rst) begin
      if (fifo_rden) cnt_rden++;
      if (m_valid) cnt_valid++; else valid_low++;
      if (m_valid && !m_ready && fifo_rden) stall_rden++;
      if (m_valid && m_ready) begin
        hs_d.push_back(m_data); hs_l.push_back(m_last); hs_c.push_back(cyc);
      end
    end

    pop = 1'b0;
    if (rst) begin
      outq.delete(); words_left = 0; bc_m = 0; ec_m = 0; es_m = 1'b0;
    end else begin
      hs  = (outq.size() > 0) && m_ready;
      pop = exp_rden;
      if (hs) begin
        if (outq[0].l) bc_m++;
        void'(outq.pop_front());
      end
      if (pop) begin
        outq.push_back('{d: fq[0], l: (words_left == 1)});
        words_left--;
      end else if (words_left == 0 && enable && !fifo_ae) begin
        words_left = BL;
      end
      if (fifo_rderr) begin
        es_m = 1'b1;
        if (ec_m < 65535) ec_m++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (pop) void'(fq.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic wait_hs(string nm, int n, int budget);
    for (int i = 0; i < budget && hs_d.size() < n; i++) tick();
    chk({nm, "_reached"}, 64'(hs_d.size() >= n), 64'd1);
  endtask

  task automatic check_seq(string nm, int n);
    int bad;
    bad = 0;
    chk({nm, "_count"}, 64'(hs_d.size()), 64'(n));
    for (int i = 0; i < n && i < hs_d.size(); i++) begin
      if (hs_d[i] !== 64'(i + 1)) bad++;
      if (hs_l[i] != ((i % BL) == BL - 1)) bad++;
    end
    chk({nm, "_seq_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    n_checks = 0; n_err = 0; cyc = 0;
    words_left = 0; bc_m = 0; ec_m = 0; es_m = 1'b0; prev_stall = 1'b0;
    rst = 1'b1; enable = 1'b0; fifo_rderr = 1'b0; m_ready = 1'b1; force_empty = 1'b0;
    load_fresh(0);
    clear_logs();

    // Reset values, pinned as literals.
    @(posedge clk); #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_rden", 64'(fifo_rden), 64'd0);
    do_reset();

    // Idle: 4 words leave almost-empty high, so no burst may start.
    load_fresh(4);
    enable = 1'b1;
    clear_logs();
    repeat (50) tick();
    chk("idle_rden_cnt", 64'(cnt_rden), 64'd0);
    chk("idle_valid_cnt", 64'(cnt_valid), 64'd0);

    // Single burst from a pulsed enable.
    enable = 1'b0;
    load_fresh(64);
    clear_logs();
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (25) tick();
    check_seq("single", 16);
    if (hs_c.size() == 16) chk("single_span", 64'(hs_c[15] - hs_c[0]), 64'd15);
    chk("single_burst_cnt", 64'(burst_cnt), 64'd1);

    // Back-to-back bursts with enable held, then an empty FIFO.
    do_reset();
    load_fresh(64);
    clear_logs();
    enable = 1'b1;
    repeat (100) tick();
    check_seq("b2b", 64);
    for (int b = 0; b < 4; b++)
      if (hs_c.size() == 64) chk("b2b_burst_span", 64'(hs_c[16*b+15] - hs_c[16*b]), 64'd15);
    chk("b2b_burst_cnt", 64'(burst_cnt), 64'd4);
    cnt_rden = 0;
    repeat (20) tick();
    chk("b2b_empty_rden", 64'(cnt_rden), 64'd0);

    // Backpressure with ready pattern 1,0,0,1.
    do_reset();
    load_fresh(64);
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      m_ready = pat[i % 4];
      tick();
    end
    m_ready = 1'b1;
    repeat (10) tick();
    check_seq("bp", 64);
    chk("bp_stall_rden", 64'(stall_rden), 64'd0);
    chk("bp_burst_cnt", 64'(burst_cnt), 64'd4);
    enable = 1'b0;

    // FIFO empty for 5 cycles after word 8.
    do_reset();
    load_fresh(64);
    clear_logs();
    enable = 1'b1; tick(); enable = 1'b0;
    wait_hs("empty_w8", 8, 50);
    force_empty = 1'b1; refresh();
    valid_low = 0;
    repeat (5) tick();
    chk("empty_valid_dropped", 64'(valid_low > 0), 64'd1);
    force_empty = 1'b0; refresh();
    repeat (30) tick();
    check_seq("empty", 16);
    chk("empty_burst_cnt", 64'(burst_cnt), 64'd1);

    // Reset after word 5 of a burst.
    do_reset();
    load_fresh(64);
    clear_logs();
    enable = 1'b1; tick(); enable = 1'b0;
    wait_hs("rst_w5", 5, 50);
    do_reset();
    chk("mrst_m_valid", 64'(m_valid), 64'd0);
    chk("mrst_m_last", 64'(m_last), 64'd0);
    chk("mrst_m_data", m_data, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rden", 64'(fifo_rden), 64'd0);
    chk("mrst_burst_cnt", 64'(burst_cnt), 64'd0);
    repeat (5) tick();

    // Read-error flags.
    for (int i = 0; i < 3; i++) begin
      fifo_rderr = 1'b1; tick();
      fifo_rderr = 1'b0; tick();
    end
    chk("err3_sticky", 64'(err_sticky), 64'd1);
`ifdef FIFO_BURST_READER_ERRCNT_EN
    chk("err3_cnt", 64'(err_cnt), 64'd3);
    fifo_rderr = 1'b1;
    repeat (70000) tick();
    fifo_rderr = 1'b0;
    tick();
    chk("err_sat", 64'(err_cnt), 64'd65535);
`else
    chk("err3_cnt", 64'(err_cnt), 64'd0);
`endif
    do_reset();
    chk("err_clr_sticky", 64'(err_sticky), 64'd0);

    // Randomized traffic against the model.
    load_fresh(0);
    nextw = 64'h1000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) < 6) begin
        fq.push_back(nextw);
        nextw++;
      end
      enable      = ($urandom_range(3) != 0);
      m_ready     = ($urandom_range(2) != 0);
      force_empty = ($urandom_range(15) == 0);
      fifo_rderr  = ($urandom_range(49) == 0);
      rst         = ($urandom_range(599) == 0);
      refresh();
      tick();
    end
    rst = 1'b0; enable = 1'b0; m_ready = 1'b1; force_empty = 1'b0; fifo_rderr = 1'b0;
    refresh();
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
